// File: rtl/id_ex_register_pkg.sv
// Shared CPU definitions used by the ID/EX pipeline register:
// ALU operation classes, control-bundle layout and register-address width.
package id_ex_register_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int FUNCT_W    = 10;
    localparam int ALU_OP_W   = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_register_sat_counter.sv
// Saturating up-counter used to count bubble/stall cycles.
// Clear has priority over increment; the count never wraps.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall/flush, load-use hazard detection
// and a saturating bubble counter.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     RS1data_i,
    input  logic [DATA_W-1:0]     RS2data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    input  logic [ALU_OP_W-1:0]   ALUOp_i,
    input  logic                  ALUSrc_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  cnt_clr_i,
    output logic [DATA_W-1:0]     RS1data_o,
    output logic [DATA_W-1:0]     RS2data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] RS1addr_o,
    output logic [REG_ADDR_W-1:0] RS2addr_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic [FUNCT_W-1:0]    funct_o,
    output logic [ALU_OP_W-1:0]   ALUOp_o,
    output logic                  ALUSrc_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic                  valid_o,
    output logic                  hazard_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    ctrl_t   ctrl_q;
    ctrl_t   ctrl_load;
    alu_op_e alu_op_q;
    logic    bubble;

    // An invalid instruction enters EX with its side-effecting controls killed.
    assign ctrl_load = '{
        alu_src:    ALUSrc_i,
        reg_write:  RegWrite_i & valid_i,
        mem_to_reg: MemtoReg_i & valid_i,
        mem_read:   MemRead_i & valid_i,
        mem_write:  MemWrite_i & valid_i
    };

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_o   <= 1'b0;
            RS1data_o <= '0;
            RS2data_o <= '0;
            imm_o     <= '0;
            RS1addr_o <= '0;
            RS2addr_o <= '0;
            RDaddr_o  <= '0;
            funct_o   <= '0;
            alu_op_q  <= ALUOP_ADD;
            ctrl_q    <= '0;
        end else if (!stall_i) begin
            valid_o   <= valid_i;
            RS1data_o <= RS1data_i;
            RS2data_o <= RS2data_i;
            imm_o     <= imm_i;
            RS1addr_o <= RS1addr_i;
            RS2addr_o <= RS2addr_i;
            RDaddr_o  <= RDaddr_i;
            funct_o   <= funct_i;
            alu_op_q  <= alu_op_e'(ALUOp_i);
            ctrl_q    <= ctrl_load;
        end
    end

    assign ALUOp_o    = alu_op_q;
    assign ALUSrc_o   = ctrl_q.alu_src;
    assign RegWrite_o = ctrl_q.reg_write;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    assign MemRead_o  = ctrl_q.mem_read;
    assign MemWrite_o = ctrl_q.mem_write;

    assign hazard_o = valid_i & valid_o & ctrl_q.mem_read & (RDaddr_o != '0)
                    & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i));

    // A bubble is any edge on which no valid instruction advances into EX.
    assign bubble = flush_i | stall_i | ~valid_i;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc  (bubble),
        .clr  (cnt_clr_i),
        .cnt  (bubble_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: table-driven vectors plus
// hand-written sequences for hazard, saturation and reset-during-stall.
module tb_id_ex_register;

    localparam int CW = 4;

    typedef struct packed {
        logic        rst, flush, stall, valid, clr;
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic [9:0]  funct;
        logic [1:0]  aluop;
        logic        alusrc, regw, m2r, mrd, mwr;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic [9:0]  funct;
        logic [1:0]  aluop;
        logic        alusrc, regw, m2r, mrd, mwr;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct packed {
        in_t         in;
        logic        e_valid;
        logic [4:0]  e_rda;
        logic [31:0] e_rs1d;
        logic        e_regw;
        logic [CW-1:0] e_cnt;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i, stall_i, flush_i, valid_i, cnt_clr_i;
    logic [31:0] RS1data_i, RS2data_i, imm_i, RS1data_o, RS2data_o, imm_o;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i, RS1addr_o, RS2addr_o, RDaddr_o;
    logic [9:0]  funct_i, funct_o;
    logic [1:0]  ALUOp_i, ALUOp_o;
    logic ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
    logic valid_o, hazard_o;
    logic [CW-1:0] bubble_cnt_o;

    id_ex_register #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
        .imm_i(imm_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
        .RDaddr_i(RDaddr_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
        .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .cnt_clr_i(cnt_clr_i),
        .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .imm_o(imm_o),
        .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .funct_o(funct_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .valid_o(valid_o), .hazard_o(hazard_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    out_t got;
    assign got = {valid_o, RS1data_o, RS2data_o, imm_o, RS1addr_o, RS2addr_o,
                  RDaddr_o, funct_o, ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o,
                  MemRead_o, MemWrite_o, bubble_cnt_o};

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t model = '0;
    out_t sb[$];

    function automatic in_t mk(logic rst, logic flush, logic stall, logic valid,
                               logic clr, logic [31:0] rs1d, logic [4:0] rda,
                               logic regw, logic mrd);
        in_t i;
        i.rst = rst; i.flush = flush; i.stall = stall; i.valid = valid; i.clr = clr;
        i.rs1d = rs1d; i.rs2d = ~rs1d; i.imm = rs1d ^ 32'h5A5A_5A5A;
        i.rda = rda; i.rs1a = rda + 5'd1; i.rs2a = rda + 5'd2;
        i.funct = {rda, rda}; i.aluop = rda[1:0]; i.alusrc = rda[0];
        i.regw = regw; i.m2r = regw; i.mrd = mrd; i.mwr = ~regw;
        return i;
    endfunction

    // Reference behaviour of one clock edge.
    function automatic out_t next_out(out_t c, in_t i);
        out_t n;
        logic bubble;
        n = c;
        bubble = i.flush | i.stall | ~i.valid;
        if (i.rst) return '0;
        if (i.flush) begin
            n = '0;
        end else if (!i.stall) begin
            n.valid = i.valid; n.rs1d = i.rs1d; n.rs2d = i.rs2d; n.imm = i.imm;
            n.rs1a = i.rs1a; n.rs2a = i.rs2a; n.rda = i.rda; n.funct = i.funct;
            n.aluop = i.aluop; n.alusrc = i.alusrc;
            n.regw = i.regw & i.valid; n.m2r = i.m2r & i.valid;
            n.mrd = i.mrd & i.valid; n.mwr = i.mwr & i.valid;
        end
        if (i.clr) n.cnt = '0;
        else if (bubble && c.cnt != {CW{1'b1}}) n.cnt = c.cnt + 1'b1;
        else n.cnt = c.cnt;
        return n;
    endfunction

    task automatic chk(string nm, logic [159:0] g, logic [159:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, g, e);
        end
    endtask

    task automatic drive(in_t i);
        rst_i = i.rst; flush_i = i.flush; stall_i = i.stall; valid_i = i.valid;
        cnt_clr_i = i.clr; RS1data_i = i.rs1d; RS2data_i = i.rs2d; imm_i = i.imm;
        RS1addr_i = i.rs1a; RS2addr_i = i.rs2a; RDaddr_i = i.rda; funct_i = i.funct;
        ALUOp_i = i.aluop; ALUSrc_i = i.alusrc; RegWrite_i = i.regw;
        MemtoReg_i = i.m2r; MemRead_i = i.mrd; MemWrite_i = i.mwr;
    endtask

    task automatic step(string nm, in_t i);
        out_t e;
        drive(i);
        model = next_out(model, i);
        sb.push_back(model);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk(nm, 160'(got), 160'(e));
    endtask

    vec_t tbl[11];
    in_t  h;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{mk(1,0,0,1,0,32'hFFFF_FFFF,5'd31,1,1), 0, 5'd0,  32'h0,         0, 4'd0};
        tbl[1]  = '{mk(0,0,0,1,0,32'h1234_5678,5'd5, 1,0), 1, 5'd5,  32'h1234_5678, 1, 4'd0};
        tbl[2]  = '{mk(0,0,0,0,0,32'h0000_AAAA,5'd9, 1,1), 0, 5'd9,  32'h0000_AAAA, 0, 4'd1};
        tbl[3]  = '{mk(0,1,1,1,0,32'h0BAD_0BAD,5'd3, 1,0), 0, 5'd0,  32'h0,         0, 4'd2};
        tbl[4]  = '{mk(0,0,0,1,0,32'h0000_1111,5'd7, 1,1), 1, 5'd7,  32'h0000_1111, 1, 4'd2};
        tbl[5]  = '{mk(0,0,1,1,0,32'h0000_2222,5'd8, 0,0), 1, 5'd7,  32'h0000_1111, 1, 4'd3};
        tbl[6]  = '{mk(0,0,1,1,0,32'h0000_2222,5'd8, 0,0), 1, 5'd7,  32'h0000_1111, 1, 4'd4};
        tbl[7]  = '{mk(0,0,1,1,0,32'h0000_2222,5'd8, 0,0), 1, 5'd7,  32'h0000_1111, 1, 4'd5};
        tbl[8]  = '{mk(0,0,0,1,0,32'h0000_3333,5'd10,0,0), 1, 5'd10, 32'h0000_3333, 0, 4'd5};
        tbl[9]  = '{mk(0,0,1,1,1,32'h0000_4444,5'd11,1,0), 1, 5'd10, 32'h0000_3333, 0, 4'd0};
        tbl[10] = '{mk(1,1,1,1,0,32'h0000_5555,5'd12,1,0), 0, 5'd0,  32'h0,         0, 4'd0};

        drive(mk(1,0,0,0,0,32'h0,5'd0,0,0));
        @(posedge clk_i);
        #1;

        for (int k = 0; k < 11; k++) begin
            step($sformatf("vec%0d_all", k), tbl[k].in);
            chk($sformatf("vec%0d_key", k),
                160'({valid_o, RDaddr_o, RS1data_o, RegWrite_o, bubble_cnt_o}),
                160'({tbl[k].e_valid, tbl[k].e_rda, tbl[k].e_rs1d, tbl[k].e_regw, tbl[k].e_cnt}));
        end

        // load-use hazard against lw x7 in EX
        step("hz_load", mk(0,0,0,1,0,32'h0000_0077,5'd7,1,1));
        h = mk(0,0,0,1,0,32'h0,5'd1,0,0);
        h.rs1a = 5'd3; h.rs2a = 5'd7; drive(h); #1;
        chk("hz_rs2_match", 160'(hazard_o), 160'(1'b1));
        h.valid = 1'b0; drive(h); #1;
        chk("hz_id_invalid", 160'(hazard_o), 160'(1'b0));
        h.valid = 1'b1; h.rs2a = 5'd8; drive(h); #1;
        chk("hz_no_match", 160'(hazard_o), 160'(1'b0));
        h.rs1a = 5'd7; drive(h); #1;
        chk("hz_rs1_match", 160'(hazard_o), 160'(1'b1));
        step("hz_load_x0", mk(0,0,0,1,0,32'h0000_0088,5'd0,1,1));
        h.rs1a = 5'd0; h.rs2a = 5'd0; drive(h); #1;
        chk("hz_rd_zero", 160'(hazard_o), 160'(1'b0));

        // saturation at 15 over 20 stall cycles, then clear beating increment
        step("sat_clr", mk(0,0,0,1,1,32'h0000_0099,5'd4,1,0));
        for (int k = 0; k < 20; k++)
            step($sformatf("sat_stall%0d", k), mk(0,0,1,1,0,32'h0,5'd0,0,0));
        chk("sat_top", 160'(bubble_cnt_o), 160'(4'd15));
        step("sat_clr_stall", mk(0,0,1,1,1,32'h0,5'd0,0,0));
        chk("sat_cleared", 160'(bubble_cnt_o), 160'(4'd0));

        // reset arriving mid-stall discards held contents
        step("rs_load", mk(0,0,0,1,0,32'hDEAD_BEEF,5'd12,1,1));
        step("rs_stall", mk(0,0,1,1,0,32'h0,5'd0,0,0));
        step("rs_reset", mk(1,0,1,1,0,32'h0,5'd12,0,0));
        chk("rs_zero", 160'(got), 160'(0));
        h = mk(0,0,0,1,0,32'h0,5'd2,0,0);
        h.rs1a = 5'd12; drive(h); #1;
        chk("rs_no_hazard", 160'(hazard_o), 160'(1'b0));
        step("rs_reload", mk(0,0,0,1,0,32'hCAFE_F00D,5'd13,1,0));
        chk("rs_reload_key", 160'({valid_o, RDaddr_o, RS1data_o, RegWrite_o}),
            160'({1'b1, 5'd13, 32'hCAFE_F00D, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk_i  in  1  sole clock, rising edge
 rst_i  in  1  reset, synchronous, active-high
 stall_i  in  1  hold current contents
 flush_i  in  1  insert bubble
 valid_i  in  1  ID-stage instruction valid
 RS1data_i, RS2data_i, imm_i  in  32 each  ID operands/immediate
 RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  ID register addresses
 funct_i  in  10  funct7/funct3
 ALUOp_i  in  2  ALU op class
 ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits
 cnt_clr_i  in  1  clear bubble counter
 (each *_i data/control above)  out  same width  registered copy, suffix _o
 valid_o  out  1  EX-stage instruction valid
 hazard_o  out  1  load-use hazard request to stall ID
 bubble_cnt_o  out  CNT_W  saturating count of bubble/stall cycles
REQ-003 Clock SHALL be clk_i only; reset SHALL be rst_i, synchronous, active-high.

Function
REQ-004 All state SHALL update only on rising clk_i.
REQ-005 Priority per edge: rst_i > flush_i > stall_i > load.
REQ-006 Load (no rst/flush/stall): every _o SHALL take its _i value one cycle later; valid_o <= valid_i.
REQ-007 Load with valid_i=0: RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o SHALL be 0; other fields loaded as-is.
REQ-008 Flush: valid_o, all 1-bit controls, ALUOp_o, RDaddr_o SHALL become 0; data fields (RS1data_o, RS2data_o, imm_o, funct_o, RS1addr_o, RS2addr_o) SHALL become 0.
REQ-009 Stall without flush: all _o and valid_o SHALL hold.
REQ-010 flush_i and stall_i together: flush SHALL win.
REQ-011 hazard_o SHALL be combinational: valid_o & MemRead_o & (RDaddr_o != 0) & (RDaddr_o == RS1addr_i | RDaddr_o == RS2addr_i), gated by valid_i.
REQ-012 hazard_o SHALL NOT feed back internally; stall_i is driven externally.
REQ-013 bubble_cnt_o SHALL increment by 1 on any non-reset edge where flush_i, stall_i, or (load with valid_i=0).
REQ-014 bubble_cnt_o SHALL saturate at 2^CNT_W-1, never wrap.
REQ-015 cnt_clr_i SHALL zero bubble_cnt_o and SHALL win over a same-cycle increment.
REQ-016 Pipeline register latency SHALL be exactly 1 cycle; no combinational path from data inputs to data outputs.

Reset
REQ-017 rst_i=1 at an edge SHALL zero every output register including valid_o and bubble_cnt_o, regardless of stall/flush/cnt_clr.
REQ-018 Reset asserted mid-stall SHALL discard held contents; first post-reset edge with rst_i=0 SHALL behave as a normal load.
REQ-019 During reset hazard_o SHALL be 0 (follows from valid_o=0).

Structure
REQ-020 ALUOp encodings, control-bundle width, and register-address width SHALL live in the shared CPU package.
REQ-021 The saturating counter SHALL be a sub-module sat_counter (inputs inc, clr; parameter CNT_W).
REQ-022 Register bank SHALL be flat flops with a single priority-encoded next-state block.

Verification
REQ-023 Load: valid_i=1, RS1data_i=0x1234_5678, RDaddr_i=5, RegWrite_i=1 -> next cycle RS1data_o=0x1234_5678, RDaddr_o=5, RegWrite_o=1, valid_o=1.
REQ-024 Stall 3 cycles then release with new inputs -> outputs hold original 3 edges, load new on 4th; bubble_cnt_o +3.
REQ-025 flush_i=1 and stall_i=1 same edge -> valid_o=0, RegWrite_o=0, RDaddr_o=0; bubble_cnt_o +1.
REQ-026 EX holds lw x7 (MemRead_o=1, RDaddr_o=7, valid_o=1), ID RS2addr_i=7, valid_i=1 -> hazard_o=1; RDaddr_o=0 -> hazard_o=0.
REQ-027 CNT_W=4, stall 20 cycles -> bubble_cnt_o stops at 15; cnt_clr_i with stall_i same edge -> 0.
REQ-028 rst_i during stall with nonzero contents -> all outputs 0 next edge; next edge with rst_i=0 loads inputs.
